// File: rtl/frame_sync_rx.sv
// frame_sync_rx: receive-side frame strobe tracker.
// Qualifies the incoming periodic strobe by pulse width and period, locks after
// LOCK_CNT consecutive good periods, then flywheels a local frame position so
// downstream logic sees a clean frame_start/pos even across missing or bad strobes.
module frame_sync_rx #(
    parameter int FRAME_LEN  = 256,
    parameter int STRB_WIDTH = 8,
    parameter int LOCK_CNT   = 3,
    parameter int LOSS_CNT   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         strb,
    output logic                         frame_start,
    output logic [$clog2(FRAME_LEN)-1:0] pos,
    output logic                         locked,
    output logic                         frame_err
);

    localparam int PW = $clog2(FRAME_LEN);
    localparam int WW = $clog2(STRB_WIDTH + 2);

    typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

    state_t          state_q, state_d;
    logic            strb_d;
    logic [WW-1:0]   width_cnt;
    logic            width_bad;
    logic [3:0]      good_cnt, good_d;
    logic [3:0]      miss_cnt, miss_d;
    logic            extra_rise, extra_d;
    logic [PW-1:0]   pos_d;
    logic            fs_d, err_d, lk_d;

    logic rise, fall, at_end;

    assign rise   = strb & ~strb_d;
    assign fall   = ~strb & strb_d;
    assign at_end = (pos == PW'(FRAME_LEN - 1));

    // Strobe delay for edge detection, and pulse width qualification.
    // The count restarts at 1 on a rise so that it includes the rise cycle itself;
    // it saturates one past the nominal width to flag a stuck-high strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            strb_d    <= 1'b0;
            width_cnt <= '0;
            width_bad <= 1'b0;
        end else begin
            strb_d <= strb;
            if (rise) begin
                width_cnt <= WW'(1);
                width_bad <= 1'b0;
            end else begin
                if (strb && (width_cnt != WW'(STRB_WIDTH + 1)))
                    width_cnt <= width_cnt + WW'(1);
                if ((fall && (width_cnt != WW'(STRB_WIDTH))) ||
                    (width_cnt == WW'(STRB_WIDTH + 1)))
                    width_bad <= 1'b1;
            end
        end
    end

    // State and output registers; every output is a flop.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= HUNT;
            pos         <= '0;
            frame_start <= 1'b0;
            frame_err   <= 1'b0;
            locked      <= 1'b0;
            good_cnt    <= '0;
            miss_cnt    <= '0;
            extra_rise  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pos         <= pos_d;
            frame_start <= fs_d;
            frame_err   <= err_d;
            locked      <= lk_d;
            good_cnt    <= good_d;
            miss_cnt    <= miss_d;
            extra_rise  <= extra_d;
        end
    end

    // Next-state and next-output decisions. The expected rise is at pos==FRAME_LEN-1
    // so that the position following it is 0.
    always_comb begin
        state_d = state_q;
        pos_d   = pos + PW'(1);
        fs_d    = 1'b0;
        err_d   = 1'b0;
        lk_d    = locked;
        good_d  = good_cnt;
        miss_d  = miss_cnt;
        extra_d = extra_rise;

        case (state_q)
            HUNT: begin
                lk_d    = 1'b0;
                extra_d = 1'b0;
                if (rise) begin
                    pos_d   = '0;
                    fs_d    = 1'b1;
                    good_d  = '0;
                    state_d = VERIFY;
                end
            end

            VERIFY: begin
                extra_d = 1'b0;
                if (at_end) begin
                    if (rise && !width_bad) begin
                        pos_d = '0;
                        fs_d  = 1'b1;
                        if ((good_cnt + 4'd1) == 4'(LOCK_CNT)) begin
                            state_d = LOCKED;
                            lk_d    = 1'b1;
                            miss_d  = '0;
                            good_d  = '0;
                        end else begin
                            good_d = good_cnt + 4'd1;
                        end
                    end else begin
                        state_d = HUNT;
                    end
                end else if (rise) begin
                    // Rise out of phase: treat it as a fresh first edge.
                    pos_d  = '0;
                    good_d = '0;
                    fs_d   = 1'b1;
                end
            end

            LOCKED: begin
                if (at_end) begin
                    // Flywheel: frame boundary is declared whether or not strb rose.
                    fs_d    = 1'b1;
                    extra_d = 1'b0;
                    if (rise && !width_bad && !extra_rise) begin
                        miss_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if ((miss_cnt + 4'd1) == 4'(LOSS_CNT)) begin
                            state_d = HUNT;
                            lk_d    = 1'b0;
                            miss_d  = '0;
                        end else begin
                            miss_d = miss_cnt + 4'd1;
                        end
                    end
                end else if (rise) begin
                    // Stray rise: remembered as a fault, never re-phases pos.
                    extra_d = 1'b1;
                end
            end

            default: begin
                state_d = HUNT;
                lk_d    = 1'b0;
            end
        endcase
    end

endmodule
